// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: instruction formats, major opcodes, immediate limits.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rv_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_REG    = 7'h33;

    // Signed byte-offset limits; B and J offsets must also be even.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;

    // Non-immediate fields carried through the pipeline.
    typedef struct packed {
        logic [2:0] fmt;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } fields_t;

endpackage

// File: rtl/instr_imm_pack.sv
// Places a byte-offset immediate into its RV32I bit positions and flags out-of-range values.
// Latency: purely combinational.
// Backpressure: none; caller owns the handshake.
module instr_imm_pack
    import rv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    logic signed [31:0] simm;
    assign simm = imm;

    // Scatter immediate bits per format; out-of-range values are still placed, truncated.
    always_comb begin
        imm_bits  = '0;
        range_err = 1'b0;
        case (fmt)
            FMT_R: begin
                imm_bits  = '0;
                range_err = 1'b0;
            end
            FMT_I: begin
                imm_bits[31:20] = imm[11:0];
                range_err       = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            end
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_err       = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_err       = (simm < IMMB_MIN) || (simm > IMMB_MAX) || imm[0];
            end
            FMT_U: begin
                imm_bits[31:12] = imm[31:12];
                range_err       = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_err       = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || imm[0];
            end
            default: begin
                imm_bits  = '0;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words tagged with a sequential program-memory address.
// Latency: two register stages; a bundle presented after edge N is visible on out_* after edge N+2.
// Backpressure: valid/ready; stalls hold out_* stable, in_ready follows out_ready combinationally.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    fields_t           in_f;
    fields_t           s1_f;
    logic              s1_valid;
    logic [31:0]       s1_imm_bits;
    logic              s1_err;
    logic [31:0]       s1_word;
    logic              s1_advance;
    logic              s2_valid;
    logic [31:0]       pack_bits;
    logic              pack_err;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        err_cnt;

    assign in_f = {in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7};

    instr_imm_pack u_imm_pack (
        .fmt       (in_fmt),
        .imm       (in_imm),
        .imm_bits  (pack_bits),
        .range_err (pack_err)
    );

    // Stage 2 frees up when empty or draining; stage 1 accepts when it is empty or moving on.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // Stage 1: capture fields, placed immediate bits and range error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_f        <= '0;
            s1_imm_bits <= '0;
            s1_err      <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_f        <= in_f;
                s1_imm_bits <= pack_bits;
                s1_err      <= pack_err;
            end
        end
    end

    // Merge register/funct fields into the word; illegal formats produce an all-zero word.
    always_comb begin
        s1_word = s1_imm_bits | {25'b0, s1_f.opcode};
        case (s1_f.fmt)
            FMT_R:        s1_word = s1_word | {s1_f.funct7, s1_f.rs2, s1_f.rs1, s1_f.funct3, s1_f.rd, 7'b0};
            FMT_I:        s1_word = s1_word | {12'b0, s1_f.rs1, s1_f.funct3, s1_f.rd, 7'b0};
            FMT_S, FMT_B: s1_word = s1_word | {7'b0, s1_f.rs2, s1_f.rs1, s1_f.funct3, 12'b0};
            FMT_U, FMT_J: s1_word = s1_word | {20'b0, s1_f.rd, 7'b0};
            default:      s1_word = '0;
        endcase
    end

    // Stage 2: output register, only reloaded when the current word has left or none is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= s1_word;
                out_err   <= s1_err;
            end
        end
    end

    // Address and error counters step only on an output transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cnt <= BASE_ADDR;
            err_cnt  <= 8'd0;
        end else if (s2_valid && out_ready) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
            if (out_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_addr  = addr_cnt;
    assign err_count = err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder checked against an encode/decode reference model.
// Latency: n/a (testbench).
// Backpressure: out_ready driven directly or randomly by the bench.
`define CHK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) passed++; \
        else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_instr_encoder;
    import rv_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;

    logic        in_ready_b, out_valid_b, out_err_b;
    logic [31:0] out_instr_b;
    logic [3:0]  out_addr_b;
    logic [7:0]  err_count_b;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    // Narrow-address instance sharing the same stimulus, for wrap-around.
    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
        .out_addr(out_addr_b), .out_err(out_err_b), .err_count(err_count_b)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          has_word;
        logic [31:0] word;
    } ent_t;

    ent_t        sb[$];
    int          total = 0, passed = 0, fails = 0;
    logic [31:0] exp_addr;
    int          exp_errs;
    bit          prev_stall;
    logic [65:0] snap;
    bit          last_fire;
    bit          pend_has_word;
    logic [31:0] pend_word;

    // Range rules stated directly as signed arithmetic.
    function automatic bit model_err(logic [2:0] fmt, logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (fmt)
            3'd0:       return 1'b0;
            3'd1, 3'd2: return (v < -2048) || (v > 2047);
            3'd3:       return (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
            3'd4:       return (imm[11:0] != 12'h0);
            3'd5:       return (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
            default:    return 1'b1;
        endcase
    endfunction

    // Value a standard RV32I immediate decoder must recover (truncated when out of range).
    function automatic logic [31:0] model_imm(logic [2:0] fmt, logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (fmt)
            3'd1, 3'd2: return 32'((v <<< 20) >>> 20);
            3'd3:       return 32'(((v <<< 19) >>> 19) & ~1);
            3'd4:       return imm & 32'hFFFF_F000;
            3'd5:       return 32'(((v <<< 11) >>> 11) & ~1);
            default:    return 32'h0;
        endcase
    endfunction

    // Immediate generator as seen by a decoding core.
    function automatic logic [31:0] decode_imm(logic [2:0] fmt, logic [31:0] w);
        case (fmt)
            3'd1:    return {{20{w[31]}}, w[31:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'h0};
            3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Fields meaningful for a format, others zeroed.
    function automatic logic [31:0] used_fields(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                                                 logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                                                 logic [6:0] f7);
        bit has_rd, has_rs1, has_rs2, has_f7;
        has_rd  = (fmt == 3'd0) || (fmt == 3'd1) || (fmt == 3'd4) || (fmt == 3'd5);
        has_rs1 = (fmt <= 3'd3);
        has_rs2 = (fmt == 3'd0) || (fmt == 3'd2) || (fmt == 3'd3);
        has_f7  = (fmt == 3'd0);
        return {op, has_rd ? rd : 5'd0, has_rs1 ? rs1 : 5'd0, has_rs2 ? rs2 : 5'd0,
                has_rs1 ? f3 : 3'd0, has_f7 ? f7 : 7'd0};
    endfunction

    // One clock: evaluate transfers about to happen at the next posedge, then advance.
    task automatic tick();
        ent_t cur;
        #1;
        last_fire = 1'b0;
        if (rst_n) begin
            if (prev_stall) `CHK("stall_hold", {out_valid, out_instr, out_addr, out_err}, snap);
            if (out_valid && out_ready) begin
                `CHK("word_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    `CHK("err_flag", out_err, model_err(cur.fmt, cur.imm));
                    if (cur.fmt <= 3'd5) begin
                        `CHK("fields", used_fields(cur.fmt, out_instr[6:0], out_instr[11:7],
                             out_instr[19:15], out_instr[24:20], out_instr[14:12], out_instr[31:25]),
                             used_fields(cur.fmt, cur.op, cur.rd, cur.rs1, cur.rs2, cur.f3, cur.f7));
                        `CHK("imm", decode_imm(cur.fmt, out_instr), model_imm(cur.fmt, cur.imm));
                    end else begin
                        `CHK("illegal_zero", out_instr, 32'h0);
                    end
                    if (cur.has_word) `CHK("directed_word", out_instr, cur.word);
                    `CHK("addr", out_addr, exp_addr);
                    `CHK("addr_wrap", out_addr_b, 4'(exp_addr + 32'd12));
                    `CHK("err_count", err_count, 8'(exp_errs));
                    `CHK("err_count_b", err_count_b, 8'(exp_errs));
                    exp_addr = exp_addr + 32'd4;
                    if (model_err(cur.fmt, cur.imm) && exp_errs < 255) exp_errs++;
                end
            end
            if (in_valid && in_ready) begin
                cur.fmt = in_fmt; cur.op = in_opcode; cur.rd = in_rd; cur.rs1 = in_rs1;
                cur.rs2 = in_rs2; cur.f3 = in_funct3; cur.f7 = in_funct7; cur.imm = in_imm;
                cur.has_word = pend_has_word; cur.word = pend_word;
                sb.push_back(cur);
                last_fire = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_valid, out_instr, out_addr, out_err};
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                          logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                          bit hw, logic [31:0] w);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        pend_has_word = hw; pend_word = w;
        in_valid = 1'b1;
    endtask

    task automatic set_rand();
        logic [31:0] imm;
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       imm = $urandom;
            1:       imm = 32'($urandom_range(0, 4000)) - 32'd2000;
            2:       imm = {$urandom, 1'b0} & 32'h001F_FFFE;
            default: begin
                case ($urandom_range(0, 9))
                    0: imm = 32'hFFFF_F800; 1: imm = 32'd2047; 2: imm = 32'd2048;
                    3: imm = 32'hFFFF_F000; 4: imm = 32'd4094; 5: imm = 32'd4096;
                    6: imm = 32'hFFF0_0000; 7: imm = 32'h000F_FFFE; 8: imm = 32'h0010_0000;
                    default: imm = 32'h1234_5000;
                endcase
            end
        endcase
        set_in(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), imm, 1'b0, 32'h0);
    endtask

    // Hold the bundle until accepted; rnd_ready randomises out_ready each cycle.
    task automatic send(bit rnd_ready);
        int n;
        n = 0;
        last_fire = 1'b0;
        while (!last_fire && n < 100) begin
            if (rnd_ready) out_ready = 1'($urandom);
            tick();
            n++;
        end
        `CHK("accept_timeout", last_fire, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain(bit rnd_ready);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            out_ready = rnd_ready ? 1'($urandom) : 1'b1;
            tick();
            n++;
        end
        `CHK("drain", sb.size(), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
        in_valid = 1'b0;
        exp_addr = 32'd0; exp_errs = 0; prev_stall = 1'b0; snap = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        `CHK("rst_out_valid", out_valid, 1'b0);
        `CHK("rst_out_instr", out_instr, 32'h0);
        `CHK("rst_out_err", out_err, 1'b0);
        `CHK("rst_err_count", err_count, 8'h0);
        `CHK("rst_addr", out_addr, 32'h0);
        `CHK("rst_addr_b", out_addr_b, 4'hC);
        `CHK("rst_in_ready", in_ready, 1'b1);

        // addi x1,x0,5 with latency check
        out_ready = 1'b1;
        set_in(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        send(1'b0);
        `CHK("latency_1", out_valid, 1'b0);
        tick();
        `CHK("latency_2", out_valid, 1'b1);
        `CHK("addi_word", out_instr, 32'h0050_0093);
        drain(1'b0);

        // sw x2,8(x1) then beq x0,x0,-4 back to back
        set_in(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020_A423);
        send(1'b0);
        set_in(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
        send(1'b0);
        drain(1'b0);

        // jal x1,2048; I imm 2048 (error); B imm 3 (error)
        set_in(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h0010_00EF);
        send(1'b0);
        set_in(FMT_I, OP_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0);
        send(1'b0);
        set_in(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd3, 1'b0, 32'h0);
        send(1'b0);
        drain(1'b0);
        `CHK("err_count_two", err_count, 8'd2);

        // six words under random backpressure, then a longer random run
        for (int i = 0; i < 6; i++) begin
            set_rand();
            send(1'b1);
        end
        drain(1'b1);
        for (int i = 0; i < 200; i++) begin
            set_rand();
            send(1'b1);
        end
        drain(1'b1);

        // saturate the error counter
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) set_in(3'd6, 7'($urandom), 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, $urandom, 1'b0, 32'h0);
            else            set_in(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'h0);
            send(1'b0);
        end
        drain(1'b0);
        `CHK("err_sat", err_count, 8'hFF);
        `CHK("err_sat_b", err_count_b, 8'hFF);

        // reset with both stages full
        out_ready = 1'b0;
        set_in(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h0);
        send(1'b0);
        set_in(FMT_R, OP_REG, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 32'd0, 1'b0, 32'h0);
        send(1'b0);
        `CHK("full_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        `CHK("mid_rst_out_valid", out_valid, 1'b0);
        `CHK("mid_rst_in_ready", in_ready, 1'b1);
        `CHK("mid_rst_err_count", err_count, 8'h0);
        sb.delete();
        exp_addr = 32'd0; exp_errs = 0; prev_stall = 1'b0;
        out_ready = 1'b1;
        set_in(FMT_I, OP_JALR, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF0, 1'b1, 32'hFF01_00E7);
        send(1'b0);
        drain(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`undef CHK
